// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side transmitter and its companions.
// State encodings, frame constants and default timing for a 50 MHz clock.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RTS   = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4,
    S_ACK   = 3'd5,
    S_DONE  = 3'd6
  } ps2_state_t;

  localparam int PS2_FRAME_BITS         = 11;
  localparam int PS2_INHIBIT_CYCLES_DEF = 6000;
  localparam int PS2_TIMEOUT_CYCLES_DEF = 1000000;
  localparam int PS2_FILTER_LEN_DEF     = 8;

  // Odd parity: the parity bit makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// Command/status bundle between a host controller and ps2_tx.
// Handshake: wr_ps2 is a one-cycle request that is taken only while tx_idle=1
// (tx_idle acts as ready); din must be valid in that cycle. Requests made while
// tx_idle=0 are dropped without effect. Exactly one of tx_done_tick /
// tx_err_tick pulses per accepted request.
interface ps2_tx_if;
  import ps2_pkg::*;

  logic       wr_ps2;
  logic [7:0] din;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_err_tick;
  ps2_state_t state_dbg;
  logic       ps2c_filt;

  modport master (
    output wr_ps2, din,
    input  tx_idle, tx_done_tick, tx_err_tick, state_dbg, ps2c_filt
  );

  modport slave (
    input  wr_ps2, din,
    output tx_idle, tx_done_tick, tx_err_tick, state_dbg, ps2c_filt
  );

endinterface

// File: rtl/ps2_clk_filter.sv
// Glitch filter for the PS/2 device clock; shared by ps2_tx and ps2_rx.
// The filtered level only changes once FILTER_LEN consecutive samples agree.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_in,
  output logic filt,
  output logic fall_tick
);

  logic [FILTER_LEN-1:0] filter_reg;
  logic                  filt_reg;
  logic                  filt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filter_reg <= '1;
      filt_reg   <= 1'b1;
    end else begin
      filter_reg <= {ps2c_in, filter_reg[FILTER_LEN-1:1]};
      filt_reg   <= filt_next;
    end
  end

  always_comb begin
    filt_next = filt_reg;
    if (&filter_reg) begin
      filt_next = 1'b1;
    end else if (~|filter_reg) begin
      filt_next = 1'b0;
    end
  end

  assign filt      = filt_reg;
  assign fall_tick = filt_reg & ~filt_next;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, start, 8 data bits LSB
// first, odd parity, stop, then the device ack; a watchdog aborts stalled frames.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF,
  parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF
) (
  input  logic     clk,
  input  logic     reset,
  ps2_tx_if.slave  bus,
  inout  wire      ps2c,
  inout  wire      ps2d
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t       state_reg, state_next;
  logic [INH_W-1:0] inh_reg, inh_next;
  logic [TO_W-1:0]  wd_reg, wd_next;
  logic [3:0]       n_reg, n_next;
  logic [8:0]       sh_reg, sh_next;
  logic             ok_reg, ok_next;

  logic drive_c, drive_d;
  logic tx_idle, done_tick, err_tick;
  logic fall_tick, ps2c_filt;
  logic in_frame, timeout;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2c_in   (ps2c),
    .filt      (ps2c_filt),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      inh_reg   <= '0;
      wd_reg    <= '0;
      n_reg     <= '0;
      sh_reg    <= '0;
      ok_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      inh_reg   <= inh_next;
      wd_reg    <= wd_next;
      n_reg     <= n_next;
      sh_reg    <= sh_next;
      ok_reg    <= ok_next;
    end
  end

  assign in_frame = (state_reg == S_START) || (state_reg == S_DATA) ||
                    (state_reg == S_STOP)  || (state_reg == S_ACK);
  assign timeout  = in_frame && (wd_reg == TO_LAST);

  // Device clock edges take priority over the watchdog in every frame state.
  always_comb begin
    state_next = state_reg;
    inh_next   = inh_reg;
    n_next     = n_reg;
    sh_next    = sh_reg;
    ok_next    = ok_reg;
    drive_c    = 1'b0;
    drive_d    = 1'b0;
    tx_idle    = 1'b0;
    done_tick  = 1'b0;
    err_tick   = 1'b0;
    wd_next    = in_frame ? (fall_tick ? '0 : wd_reg + TO_W'(1)) : '0;

    unique case (state_reg)
      S_IDLE: begin
        tx_idle = 1'b1;
        if (bus.wr_ps2) begin
          sh_next    = {odd_parity(bus.din), bus.din};
          inh_next   = '0;
          ok_next    = 1'b0;
          state_next = S_RTS;
        end
      end

      S_RTS: begin
        drive_c = 1'b1;
        if (inh_reg == INH_LAST) begin
          state_next = S_START;
        end else begin
          inh_next = inh_reg + INH_W'(1);
        end
      end

      S_START: begin
        if (fall_tick) begin
          drive_d    = 1'b1;
          n_next     = 4'd8;
          state_next = S_DATA;
        end else if (timeout) begin
          ok_next    = 1'b0;
          state_next = S_DONE;
        end else begin
          drive_d = 1'b1;
        end
      end

      S_DATA: begin
        if (fall_tick) begin
          drive_d = ~sh_reg[0];
          sh_next = {1'b1, sh_reg[8:1]};
          if (n_reg == 4'd0) begin
            state_next = S_STOP;
          end else begin
            n_next = n_reg - 4'd1;
          end
        end else if (timeout) begin
          ok_next    = 1'b0;
          state_next = S_DONE;
        end else begin
          drive_d = ~sh_reg[0];
        end
      end

      S_STOP: begin
        if (fall_tick) begin
          state_next = S_ACK;
        end else if (timeout) begin
          ok_next    = 1'b0;
          state_next = S_DONE;
        end
      end

      S_ACK: begin
        if (fall_tick) begin
          ok_next    = (ps2d == 1'b0);
          state_next = S_DONE;
        end else if (timeout) begin
          ok_next    = 1'b0;
          state_next = S_DONE;
        end
      end

      S_DONE: begin
        done_tick  = ok_reg;
        err_tick   = ~ok_reg;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Open-collector: only ever pull low, otherwise release to the pull-ups.
  assign ps2c = drive_c ? 1'b0 : 1'bz;
  assign ps2d = drive_d ? 1'b0 : 1'bz;

  assign bus.tx_idle      = tx_idle;
  assign bus.tx_done_tick = done_tick;
  assign bus.tx_err_tick  = err_tick;
  assign bus.state_dbg    = state_reg;
  assign bus.ps2c_filt    = ps2c_filt;

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: a device model on pulled-up lines decodes
// each frame and checks it against a queue of expected {parity, byte} words.
module tb_ps2_tx;
  import ps2_pkg::*;

  localparam int INHIBIT = 100;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 100;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wire  ps2c, ps2d;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2d = dev_data_low ? 1'b0 : 1'bz;

  ps2_tx_if bus ();

  ps2_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .TIMEOUT_CYCLES (TIMEOUT),
    .FILTER_LEN     (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .ps2c  (ps2c),
    .ps2d  (ps2d)
  );

  // ---------------- scoreboard ----------------
  int         n_checks  = 0;
  int         n_fail    = 0;
  int         done_cnt  = 0;
  int         err_cnt   = 0;
  int         bfm_falls = 0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0] din;
    logic       par;
    bit         ack;
    bit         exp_ok;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  always @(negedge clk) begin
    if (bus.tx_done_tick || bus.tx_err_tick) begin
      if (bus.tx_done_tick) done_cnt++;
      if (bus.tx_err_tick)  err_cnt++;
      check("tick_exclusive", 32'(bus.tx_done_tick & bus.tx_err_tick), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d, input logic par, input bit push);
    @(negedge clk);
    bus.din    = d;
    bus.wr_ps2 = 1'b1;
    if (push) exp_q.push_back({par, d});
    @(negedge clk);
    bus.wr_ps2 = 1'b0;
    check("idle_drops_after_accept", 32'(bus.tx_idle), 32'd0);
  endtask

  // Device model: clocks 10 data/stop pulses sampling on each rising edge, then
  // two more pulses; the host samples the ack on the last falling edge.
  task automatic bfm_frame(input bit do_ack, input int abort_at);
    logic [10:0] bits;
    logic [8:0]  exp;
    int          waited;
    int          low;
    bit          seen;
    bits      = '0;
    waited    = 0;
    low       = 0;
    seen      = 0;
    bfm_falls = 0;
    while (!seen && waited < 4 * INHIBIT) begin
      @(negedge clk);
      waited++;
      if (ps2c === 1'b0) low++;
      if (ps2c === 1'b1 && ps2d === 1'b0) seen = 1;
    end
    if (!seen) begin
      bound_expired("bfm_start_condition");
      return;
    end
    check("rts_low_cycles", 32'(low), 32'(INHIBIT));
    bits[0] = ps2d;
    repeat (HALF) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      bfm_falls++;
      if (bfm_falls == abort_at) begin
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b0;
        return;
      end
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      @(negedge clk);
      bits[i] = ps2d;
      repeat (HALF - 1) @(negedge clk);
    end
    dev_clk_low = 1'b1;
    bfm_falls++;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    dev_data_low = do_ack;
    repeat (HALF / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    bfm_falls++;
    repeat (HALF) @(negedge clk);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (HALF) @(negedge clk);

    if (exp_q.size() == 0) begin
      bound_expired("scoreboard_unexpected_frame");
    end else begin
      exp = exp_q.pop_front();
      check("frame_start", 32'(bits[0]), 32'd0);
      check("frame_data", 32'(bits[8:1]), 32'(exp[7:0]));
      check("frame_parity", 32'(bits[9]), 32'(exp[8]));
      check("frame_stop", 32'(bits[10]), 32'd1);
    end
  endtask

  task automatic wait_tick(input int d0, input int e0);
    int waited;
    waited = 0;
    while (done_cnt == d0 && err_cnt == e0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) bound_expired("tick_wait");
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic par, input bit do_ack, input bit exp_ok);
    int d0;
    int e0;
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      send_byte(d, par, 1'b1);
      bfm_frame(do_ack, 0);
    join
    wait_tick(d0, e0);
    check("done_tick_count", 32'(done_cnt - d0), 32'(exp_ok));
    check("err_tick_count", 32'(err_cnt - e0), 32'(!exp_ok));
    check("idle_after_frame", 32'(bus.tx_idle), 32'd1);
    check("ps2c_released", 32'(ps2c), 32'd1);
    check("ps2d_released", 32'(ps2d), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0;
    int e0;
    int cyc;

    bus.wr_ps2 = 1'b0;
    bus.din    = 8'h00;

    vecs[0] = '{din: 8'hED, par: 1'b1, ack: 1'b1, exp_ok: 1'b1};
    vecs[1] = '{din: 8'h00, par: 1'b1, ack: 1'b1, exp_ok: 1'b1};
    vecs[2] = '{din: 8'hFF, par: 1'b1, ack: 1'b1, exp_ok: 1'b1};
    vecs[3] = '{din: 8'h01, par: 1'b0, ack: 1'b1, exp_ok: 1'b1};
    vecs[4] = '{din: 8'hED, par: 1'b1, ack: 1'b0, exp_ok: 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Reset asserted mid-idle, away from a clock edge
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset_ps2c", 32'(ps2c), 32'd1);
    check("reset_ps2d", 32'(ps2d), 32'd1);
    check("reset_tx_idle", 32'(bus.tx_idle), 32'd1);
    check("reset_done_tick", 32'(bus.tx_done_tick), 32'd0);
    check("reset_err_tick", 32'(bus.tx_err_tick), 32'd0);
    check("reset_state", 32'(bus.state_dbg), 32'(S_IDLE));
    check("reset_filter", 32'(bus.ps2c_filt), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Table: normal frames, parity corners, missing ack
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].din, vecs[i].par, vecs[i].ack, vecs[i].exp_ok);
    end

    // Device never clocks: watchdog fires INHIBIT+TIMEOUT cycles after accept
    d0 = done_cnt;
    send_byte(8'hED, 1'b1, 1'b0);
    cyc = 0;
    while (bus.tx_err_tick !== 1'b1 && cyc < INHIBIT + TIMEOUT + 200) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.tx_err_tick !== 1'b1) begin
      bound_expired("timeout_err_tick");
    end else begin
      check("timeout_latency", 32'(cyc), 32'(INHIBIT + TIMEOUT));
      check("timeout_ps2d_released", 32'(ps2d), 32'd1);
      check("timeout_ps2c_released", 32'(ps2c), 32'd1);
    end
    repeat (2) @(negedge clk);
    check("timeout_no_done", 32'(done_cnt - d0), 32'd0);
    run_frame(8'hAA, 1'b1, 1'b1, 1'b1);

    // wr_ps2 during the data phase is ignored
    d0 = done_cnt;
    e0 = err_cnt;
    bfm_falls = 0;
    fork
      send_byte(8'hED, 1'b1, 1'b1);
      bfm_frame(1'b1, 0);
      begin
        int w;
        w = 0;
        while (bfm_falls < 3 && w < 5000) begin
          @(negedge clk);
          w++;
        end
        repeat (20) @(negedge clk);
        check("inject_in_data_state", 32'(bus.state_dbg), 32'(S_DATA));
        bus.din    = 8'h55;
        bus.wr_ps2 = 1'b1;
        @(negedge clk);
        bus.wr_ps2 = 1'b0;
      end
    join
    wait_tick(d0, e0);
    check("inject_done_count", 32'(done_cnt - d0), 32'd1);
    check("inject_err_count", 32'(err_cnt - e0), 32'd0);
    check("inject_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (400) @(negedge clk);
    check("inject_no_second_frame", 32'(bus.tx_idle), 32'd1);
    check("inject_done_still_one", 32'(done_cnt - d0), 32'd1);

    // Reset after the 4th device falling edge, then a clean retransmit
    fork
      send_byte(8'h00, 1'b1, 1'b0);
      bfm_frame(1'b1, 4);
    join
    check("abort_data_driven_low", 32'(ps2d), 32'd0);
    check("abort_busy", 32'(bus.tx_idle), 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_reset_ps2d", 32'(ps2d), 32'd1);
    check("abort_reset_ps2c", 32'(ps2c), 32'd1);
    check("abort_reset_tx_idle", 32'(bus.tx_idle), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    run_frame(8'hF4, 1'b0, 1'b1, 1'b1);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL global_watchdog: simulation did not finish, got %0d checks, expected completion", n_checks);
    $fatal(1, "global watchdog expired");
  end

endmodule
